// File: rtl/csr_pkg.sv
// Shared definitions for the counter CSR file: op encoding, CSR address map, hpm index decode.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_READ = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_t;

    localparam int unsigned HPM_BASE = 3;

    localparam logic [11:0] CSR_MCOUNTINHIBIT   = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT_BASE  = 12'h323;
    localparam logic [11:0] CSR_MCYCLE          = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET        = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER_BASE = 12'hB03;
    localparam logic [11:0] CSR_CYCLE           = 12'hC00;
    localparam logic [11:0] CSR_INSTRET         = 12'hC02;
    localparam logic [11:0] CSR_HPMCOUNTER_BASE = 12'hC03;

    localparam logic [3:0] CSR_PAGE_M = 4'hB;
    localparam logic [3:0] CSR_PAGE_U = 4'hC;

    // hpm slot from the low five address bits; caller checks off >= HPM_BASE and range
    function automatic logic [4:0] hpm_index(input logic [4:0] off);
        return off - 5'(HPM_BASE);
    endfunction

endpackage

// File: rtl/csr_counter.sv
// One counter: low/high 32-bit writes win over the increment; wraps silently at full width.
module csr_counter #(
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     inhibit,
    input  logic                     wr_lo,
    input  logic                     wr_hi,
    input  logic [31:0]              wdata,
    output logic [COUNTER_WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (wr_lo) begin
            value <= {value[COUNTER_WIDTH-1:32], wdata};
        end else if (wr_hi) begin
            value <= {wdata[COUNTER_WIDTH-33:0], value[31:0]};
        end else if (inc && !inhibit) begin
            value <= value + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/csr_counter_file.sv
// Counter CSR file: mcycle, minstret, hpm counters/events, mcountinhibit; one registered response per request.
module csr_counter_file
    import csr_pkg::*;
#(
    parameter int unsigned NUM_HPM       = 4,
    parameter int unsigned NUM_EVENTS    = 8,
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_instret,
    input  logic [NUM_EVENTS-1:0] i_events,
    input  logic                  i_csr_valid,
    input  logic [11:0]           i_csr_id,
    input  logic [1:0]            i_csr_op,
    input  logic [31:0]           i_csr_wdata,
    output logic                  o_csr_ready,
    output logic [31:0]           o_csr_rdata,
    output logic                  o_csr_illegal
);

    localparam int unsigned NUM_CNT   = NUM_HPM + 2;
    localparam int unsigned HPM_SLOTS = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int unsigned EVW       = $clog2(NUM_EVENTS + 1);
    localparam logic [31:0] INH_MASK  = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << HPM_BASE);

    logic [COUNTER_WIDTH-1:0] cnt [NUM_CNT];
    logic [EVW-1:0]           mhpmevent [HPM_SLOTS];
    logic [31:0]              mcountinhibit;

    logic [NUM_CNT-1:0] inc, inh, wr_lo, wr_hi;
    logic [4:0]  off, idx;
    logic        hi, hpm_ok, is_cnt, is_inh, is_evt, shadow, wr_intent, illegal, do_wr;
    int          cnt_sel;
    logic [31:0] old, nxt;
    csr_op_t     op;

    // Address decode, legality, read mux and RW/RS/RC ALU
    always_comb begin
        op        = csr_op_t'(i_csr_op);
        off       = i_csr_id[4:0];
        hi        = i_csr_id[7];
        idx       = hpm_index(off);
        hpm_ok    = (off >= 5'(HPM_BASE)) && (int'(idx) < int'(NUM_HPM));
        shadow    = (i_csr_id[11:8] == CSR_PAGE_U);
        is_cnt    = ((i_csr_id[11:8] == CSR_PAGE_M) || shadow) && (i_csr_id[6:5] == 2'b00)
                    && ((off == 5'd0) || (off == 5'd2) || hpm_ok);
        is_inh    = (i_csr_id == CSR_MCOUNTINHIBIT);
        is_evt    = (i_csr_id[11:5] == CSR_MHPMEVENT_BASE[11:5]) && hpm_ok;
        cnt_sel   = (off == 5'd0) ? 0 : (off == 5'd2) ? 1 : 2 + int'(idx);
        wr_intent = (op == CSR_RW) || ((op != CSR_READ) && (i_csr_wdata != 32'h0));
        illegal   = !(is_cnt || is_inh || is_evt) || (wr_intent && shadow);
        do_wr     = i_csr_valid && !illegal && wr_intent;

        old = '0;
        if (is_inh) old = mcountinhibit;
        for (int k = 0; k < int'(NUM_CNT); k++) begin
            if (is_cnt && cnt_sel == k) old = hi ? 32'(cnt[k] >> 32) : cnt[k][31:0];
        end
        for (int i = 0; i < int'(NUM_HPM); i++) begin
            if (is_evt && int'(idx) == i) old = 32'(mhpmevent[i]);
        end

        case (op)
            CSR_RW:  nxt = i_csr_wdata;
            CSR_RS:  nxt = old | i_csr_wdata;
            CSR_RC:  nxt = old & ~i_csr_wdata;
            default: nxt = old;
        endcase

        for (int k = 0; k < int'(NUM_CNT); k++) begin
            wr_lo[k] = do_wr && is_cnt && (cnt_sel == k) && !hi;
            wr_hi[k] = do_wr && is_cnt && (cnt_sel == k) && hi;
        end
    end

    // Per-counter increment and inhibit
    always_comb begin
        inc    = '0;
        inh    = '0;
        inc[0] = 1'b1;
        inc[1] = i_instret;
        inh[0] = mcountinhibit[0];
        inh[1] = mcountinhibit[2];
        for (int i = 0; i < int'(NUM_HPM); i++) begin
            inh[2+i] = mcountinhibit[int'(HPM_BASE) + i];
            for (int e = 0; e < int'(NUM_EVENTS); e++) begin
                if (mhpmevent[i] == EVW'(e + 1) && i_events[e]) inc[2+i] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_CNT); k++) begin : g_cnt
        csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_counter (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc[k]),
            .inhibit (inh[k]),
            .wr_lo   (wr_lo[k]),
            .wr_hi   (wr_hi[k]),
            .wdata   (i_csr_wdata),
            .value   (cnt[k])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcountinhibit <= '0;
            for (int i = 0; i < int'(HPM_SLOTS); i++) mhpmevent[i] <= '0;
        end else begin
            if (do_wr && is_inh) mcountinhibit <= nxt & INH_MASK;
            for (int i = 0; i < int'(NUM_HPM); i++) begin
                if (do_wr && is_evt && int'(idx) == i) mhpmevent[i] <= nxt[EVW-1:0];
            end
        end
    end

    // Response register: ready follows valid by one cycle; illegal accesses read 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_csr_ready   <= 1'b0;
            o_csr_rdata   <= '0;
            o_csr_illegal <= 1'b0;
        end else begin
            o_csr_ready   <= i_csr_valid;
            o_csr_rdata   <= (i_csr_valid && !illegal) ? old : 32'h0;
            o_csr_illegal <= i_csr_valid && illegal;
        end
    end

endmodule

// File: tb/tb_csr_counter_file.sv
// Directed, cycle-exact vectors for csr_counter_file: one table row per clock edge.
module tb_csr_counter_file;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [11:0] id;
        logic [31:0] wdata;
        logic        instret;
        logic [7:0]  events;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_instret = 1'b0;
    logic [7:0]  i_events = '0;
    logic        i_csr_valid = 1'b0;
    logic [11:0] i_csr_id = '0;
    logic [1:0]  i_csr_op = '0;
    logic [31:0] i_csr_wdata = '0;
    logic        o_csr_ready;
    logic [31:0] o_csr_rdata;
    logic        o_csr_illegal;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vq[$];

    csr_counter_file #(.NUM_HPM(4), .NUM_EVENTS(8), .COUNTER_WIDTH(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_instret     (i_instret),
        .i_events      (i_events),
        .i_csr_valid   (i_csr_valid),
        .i_csr_id      (i_csr_id),
        .i_csr_op      (i_csr_op),
        .i_csr_wdata   (i_csr_wdata),
        .o_csr_ready   (o_csr_ready),
        .o_csr_rdata   (o_csr_rdata),
        .o_csr_illegal (o_csr_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rq(input logic [1:0] op, input logic [11:0] id, input logic [31:0] wd,
                      input logic ir, input logic [7:0] ev, input logic [31:0] rd, input logic il);
        vq.push_back('{1'b1, op, id, wd, ir, ev, rd, il});
    endtask

    task automatic idle(input int n, input logic ir, input logic [7:0] ev);
        for (int i = 0; i < n; i++) vq.push_back('{1'b0, 2'b00, 12'h0, 32'h0, ir, ev, 32'h0, 1'b0});
    endtask

    // Drive each row just after an edge, check its response just after the following edge
    task automatic run_table(input string tag);
        for (int r = 0; r < vq.size(); r++) begin
            i_csr_valid = vq[r].valid;
            i_csr_op    = vq[r].op;
            i_csr_id    = vq[r].id;
            i_csr_wdata = vq[r].wdata;
            i_instret   = vq[r].instret;
            i_events    = vq[r].events;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d] ready", tag, r), 32'(o_csr_ready), 32'(vq[r].valid));
            check($sformatf("%s[%0d] rdata", tag, r), o_csr_rdata, vq[r].rdata);
            check($sformatf("%s[%0d] illegal", tag, r), 32'(o_csr_illegal), 32'(vq[r].ill));
        end
        i_csr_valid = 1'b0;
        i_instret   = 1'b0;
        i_events    = '0;
        vq.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(o_csr_ready), 32'h0);
        check("reset rdata", o_csr_rdata, 32'h0);
        check("reset illegal", 32'(o_csr_illegal), 32'h0);
        reset = 1'b1;

        // Row n of this table is clock edge n after reset release (mcycle old value = n-1)
        idle(10, 1'b0, 8'h00);                                   // edges 1..10
        rq(2'b00, 12'hB00, 32'h0, 1'b0, 8'h00, 32'd10, 1'b0);    // 11
        rq(2'b00, 12'hB80, 32'h0, 1'b0, 8'h00, 32'd0, 1'b0);     // 12
        rq(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 8'h00, 32'd12, 1'b0); // 13
        idle(1, 1'b0, 8'h00);                                    // 14: carry into high half
        rq(2'b00, 12'hB80, 32'h0, 1'b0, 8'h00, 32'd1, 1'b0);     // 15
        rq(2'b00, 12'hB00, 32'h0, 1'b0, 8'h00, 32'd1, 1'b0);     // 16
        rq(2'b01, 12'h323, 32'd2, 1'b0, 8'h00, 32'd0, 1'b0);     // 17
        idle(5, 1'b0, 8'h02);                                    // 18..22
        rq(2'b00, 12'hB03, 32'h0, 1'b0, 8'h00, 32'd5, 1'b0);     // 23
        rq(2'b10, 12'h320, 32'h8, 1'b0, 8'h00, 32'd0, 1'b0);     // 24
        idle(5, 1'b0, 8'h02);                                    // 25..29 inhibited
        rq(2'b00, 12'hB03, 32'h0, 1'b0, 8'h00, 32'd5, 1'b0);     // 30
        rq(2'b00, 12'h320, 32'h0, 1'b0, 8'h00, 32'h8, 1'b0);     // 31
        rq(2'b01, 12'hC00, 32'h1234, 1'b0, 8'h00, 32'd0, 1'b1);  // 32
        rq(2'b10, 12'hC00, 32'h0, 1'b0, 8'h00, 32'd18, 1'b0);    // 33
        rq(2'b00, 12'hB07, 32'h0, 1'b0, 8'h00, 32'd0, 1'b1);     // 34
        rq(2'b00, 12'hC80, 32'h0, 1'b0, 8'h00, 32'd1, 1'b0);     // 35
        rq(2'b01, 12'hB02, 32'd100, 1'b1, 8'h00, 32'd0, 1'b0);   // 36 write beats retire
        rq(2'b00, 12'hB02, 32'h0, 1'b0, 8'h00, 32'd100, 1'b0);   // 37
        idle(1, 1'b1, 8'h00);                                    // 38
        rq(2'b00, 12'hC02, 32'h0, 1'b0, 8'h00, 32'd101, 1'b0);   // 39
        rq(2'b11, 12'h320, 32'h8, 1'b0, 8'h00, 32'h8, 1'b0);     // 40
        rq(2'b00, 12'h320, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0);     // 41
        rq(2'b00, 12'h321, 32'h0, 1'b0, 8'h00, 32'h0, 1'b1);     // 42
        rq(2'b01, 12'h323, 32'hFF, 1'b0, 8'h00, 32'd2, 1'b0);    // 43
        rq(2'b00, 12'h323, 32'h0, 1'b0, 8'h00, 32'hF, 1'b0);     // 44
        idle(1, 1'b0, 8'hFF);                                    // 45 selector out of range
        rq(2'b00, 12'hB03, 32'h0, 1'b0, 8'h00, 32'd5, 1'b0);     // 46
        rq(2'b01, 12'h320, 32'hFFFF_FFFF, 1'b0, 8'h00, 32'h0, 1'b0); // 47
        rq(2'b00, 12'h320, 32'h0, 1'b0, 8'h00, 32'h7D, 1'b0);    // 48
        rq(2'b00, 12'hB00, 32'h0, 1'b0, 8'h00, 32'd33, 1'b0);    // 49 mcycle frozen
        rq(2'b00, 12'hB00, 32'h0, 1'b0, 8'h00, 32'd33, 1'b0);    // 50
        run_table("main");

        // Reset asserted while a request is in flight
        i_csr_valid = 1'b1;
        i_csr_op    = 2'b01;
        i_csr_id    = 12'h320;
        i_csr_wdata = 32'h0;
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset ready", 32'(o_csr_ready), 32'h0);
        check("midreset rdata", o_csr_rdata, 32'h0);
        i_csr_valid = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post-release ready", 32'(o_csr_ready), 32'h0);

        rq(2'b00, 12'hB00, 32'h0, 1'b0, 8'h00, 32'd1, 1'b0);
        rq(2'b00, 12'hB80, 32'h0, 1'b0, 8'h00, 32'd0, 1'b0);
        rq(2'b00, 12'h320, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0);
        rq(2'b00, 12'hB02, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0);
        rq(2'b00, 12'hB03, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0);
        rq(2'b00, 12'h323, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0);
        run_table("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
